// File: rtl/efuse_pkg.sv
// Shared definitions for the eFuse sequencing controller.
// Holds the sequencer state encoding and the fuse array geometry.
package efuse_pkg;

   localparam int EFUSE_BITS_PER_WORD = 32;
   localparam int EFUSE_WORDS         = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_ARM       = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4,
      ST_CLEAR     = 3'd5,
      ST_FINISH    = 3'd6
   } efuse_state_e;

endpackage

// File: rtl/efuse_seq_ctrl.sv
// eFuse word sequencer: walks the 32 bits of one fuse word, issuing one
// strobe per bit to the AEN generator for reads or programs, with a per-bit
// timeout and a configurable idle gap between accesses.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_write, cmd_word, cmd_wdata   1=program/0=read, word index, program data
//   rg_efuse_tpgm, rg_efuse_tgap     strobe width, idle cycles between bits
//   efuse_reg_mode .. efuse_addr     controls to the AEN generator
//   efuse_aen_done, efuse_dout       generator done level, macro read bit
//   rdata, rdata_valid, busy, err    read result, result strobe, status
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a command, cmd_ready high
// ISSUE      | refresh pulse for the current bit, or skip it
// ARM        | two cycles letting the generator drop done
// WAIT_DONE  | waiting for done or the timeout
// GAP        | rg_efuse_tgap idle cycles before the next bit
// CLEAR      | refresh with pgmen=rden=0 to clear generator address memory
// FINISH     | rdata_valid pulse on reads, then back to IDLE
module efuse_seq_ctrl
   import efuse_pkg::*;
#(
   parameter int TMO_MARGIN = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [2:0]  cmd_word,
   input  logic [31:0] cmd_wdata,
   input  logic [9:0]  rg_efuse_tpgm,
   input  logic [3:0]  rg_efuse_tgap,
   output logic        efuse_reg_mode,
   output logic        efuse_refresh,
   output logic        efuse_pgmen,
   output logic        efuse_rden,
   output logic [7:0]  efuse_addr,
   input  logic        efuse_aen_done,
   input  logic        efuse_dout,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        busy,
   output logic        err
);

   efuse_state_e state_q, state_d;

   logic        wr_q;
   logic [2:0]  word_q;
   logic [31:0] wdata_q;
   logic [4:0]  bit_q;
   logic        arm_q;
   logic [9:0]  tmo_q;
   logic [3:0]  gap_q;

   logic [7:0]  cur_addr;
   logic        skip;
   logic        last_bit;
   logic [10:0] tmo_limit;
   logic        tmo_hit;
   logic        wait_exit;
   logic        bit_done;
   logic        in_cmd;

   assign cur_addr  = {word_q, bit_q};
   // Address 0 is reserved; zero program bits need no strobe.
   assign skip      = (cur_addr == 8'd0) || (wr_q && !wdata_q[bit_q]);
   assign last_bit  = (bit_q == 5'(EFUSE_BITS_PER_WORD - 1));
   assign tmo_limit = {1'b0, rg_efuse_tpgm} + 11'(TMO_MARGIN);
   // The all-ones term keeps a limit beyond the counter range from hanging.
   assign tmo_hit   = (({1'b0, tmo_q} + 11'd1) >= tmo_limit) || (tmo_q == 10'h3ff);
   assign wait_exit = (state_q == ST_WAIT_DONE) && (efuse_aen_done || tmo_hit);
   assign bit_done  = ((state_q == ST_ISSUE) && skip)
                    || (wait_exit && (rg_efuse_tgap == 4'd0))
                    || ((state_q == ST_GAP) && (gap_q == 4'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:      if (cmd_valid) state_d = ST_ISSUE;
         ST_ISSUE:     if (!skip) state_d = ST_ARM;
                       else if (last_bit) state_d = ST_CLEAR;
         ST_ARM:       if (arm_q) state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (wait_exit) begin
                          if (rg_efuse_tgap != 4'd0) state_d = ST_GAP;
                          else if (last_bit)         state_d = ST_CLEAR;
                          else                       state_d = ST_ISSUE;
                       end
         ST_GAP:       if (gap_q == 4'd0) state_d = last_bit ? ST_CLEAR : ST_ISSUE;
         ST_CLEAR:     state_d = ST_FINISH;
         ST_FINISH:    state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         word_q  <= 3'd0;
         wdata_q <= 32'd0;
         bit_q   <= 5'd0;
         arm_q   <= 1'b0;
         tmo_q   <= 10'd0;
         gap_q   <= 4'd0;
         rdata   <= 32'd0;
         err     <= 1'b0;
      end else begin
         if ((state_q == ST_IDLE) && cmd_valid) begin
            wr_q    <= cmd_write;
            word_q  <= cmd_word;
            wdata_q <= cmd_wdata;
            bit_q   <= 5'd0;
            err     <= 1'b0;
            if (!cmd_write) rdata <= 32'd0;
         end
         if (state_q == ST_ISSUE) arm_q <= 1'b0;
         if (state_q == ST_ARM) begin
            arm_q <= 1'b1;
            tmo_q <= 10'd0;
         end
         if ((state_q == ST_WAIT_DONE) && (tmo_q != 10'h3ff)) tmo_q <= tmo_q + 10'd1;
         if (wait_exit) begin
            gap_q <= rg_efuse_tgap - 4'd1;
            if (efuse_aen_done) begin
               if (!wr_q) rdata[bit_q] <= efuse_dout;
            end else begin
               err <= 1'b1;
               if (!wr_q) rdata[bit_q] <= 1'b0;
            end
         end
         if ((state_q == ST_GAP) && (gap_q != 4'd0)) gap_q <= gap_q - 4'd1;
         if (bit_done && !last_bit) bit_q <= bit_q + 5'd1;
      end
   end

   always_comb begin
      in_cmd         = (state_q == ST_ISSUE) || (state_q == ST_ARM)
                    || (state_q == ST_WAIT_DONE) || (state_q == ST_GAP);
      cmd_ready      = (state_q == ST_IDLE);
      busy           = (state_q != ST_IDLE);
      efuse_reg_mode = busy;
      efuse_pgmen    = in_cmd && wr_q;
      efuse_rden     = in_cmd && !wr_q;
      efuse_addr     = in_cmd ? cur_addr : 8'd0;
      efuse_refresh  = ((state_q == ST_ISSUE) && !skip) || (state_q == ST_CLEAR);
      rdata_valid    = (state_q == ST_FINISH) && !wr_q;
   end

endmodule

// File: tb/tb_efuse_seq_ctrl.sv
// Self-checking bench for efuse_seq_ctrl with a simple AEN generator model.
module tb_efuse_seq_ctrl;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [2:0]  cmd_word;
   logic [31:0] cmd_wdata;
   logic [9:0]  rg_efuse_tpgm;
   logic [3:0]  rg_efuse_tgap;
   logic        efuse_reg_mode, efuse_refresh, efuse_pgmen, efuse_rden;
   logic [7:0]  efuse_addr;
   logic        efuse_aen_done, efuse_dout;
   logic [31:0] rdata;
   logic        rdata_valid, busy, err;

   efuse_seq_ctrl #(.TMO_MARGIN(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_word(cmd_word), .cmd_wdata(cmd_wdata),
      .rg_efuse_tpgm(rg_efuse_tpgm), .rg_efuse_tgap(rg_efuse_tgap),
      .efuse_reg_mode(efuse_reg_mode), .efuse_refresh(efuse_refresh),
      .efuse_pgmen(efuse_pgmen), .efuse_rden(efuse_rden), .efuse_addr(efuse_addr),
      .efuse_aen_done(efuse_aen_done), .efuse_dout(efuse_dout),
      .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Generator model: done drops on each refresh and rises tpgm cycles later.
   logic       gen_resp = 1'b1;
   logic       gen_ones = 1'b0;
   logic       g_done, g_act;
   logic [9:0] g_cnt;
   logic [7:0] g_addr;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g_done <= 1'b0; g_act <= 1'b0; g_cnt <= 10'd0; g_addr <= 8'd0;
      end else if (efuse_refresh) begin
         g_done <= 1'b0;
         g_act  <= (efuse_pgmen || efuse_rden) && gen_resp;
         g_cnt  <= rg_efuse_tpgm - 10'd1;
         g_addr <= efuse_addr;
      end else if (g_act) begin
         if (g_cnt <= 10'd1) begin
            g_done <= 1'b1; g_act <= 1'b0;
         end else g_cnt <= g_cnt - 10'd1;
      end
   end
   assign efuse_aen_done = g_done;
   assign efuse_dout     = gen_ones ? 1'b1 : g_addr[0];

   // Expected behaviour of the current command.
   logic        cur_wr = 1'b0;
   logic [7:0]  exp_q[$];
   int          skq[$];
   logic [31:0] exp_rdata = 32'd0;
   logic        exp_err = 1'b0;
   int          n_exp = 0;
   int          acc_cnt = 0, clr_cnt = 0, rv_cnt = 0;
   logic [7:0]  log_addr[$];
   int          log_cyc[$];
   int          done_cyc = 0, prev_ref_cyc = 0, last_d2r = 0;
   logic        have_done = 1'b0, have_prev_ref = 1'b0, done_prev = 1'b0;

   always @(negedge clk) begin
      int sk;
      chk("ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      chk("reg_mode", 32'(efuse_reg_mode), 32'(busy));
      if (!busy)
         chk("idle_quiet", {19'd0, efuse_refresh, efuse_pgmen, efuse_rden, rdata_valid, efuse_addr}, 32'd0);
      if (efuse_pgmen || efuse_rden)
         chk("direction", {30'd0, efuse_pgmen, efuse_rden}, {30'd0, cur_wr, !cur_wr});
      if (efuse_refresh && (efuse_pgmen || efuse_rden)) begin
         acc_cnt++;
         log_addr.push_back(efuse_addr);
         log_cyc.push_back(cyc);
         if (exp_q.size() == 0) chk("unexpected_refresh", 32'(efuse_addr), 32'hffff_ffff);
         else begin
            chk("refresh_addr", 32'(efuse_addr), 32'(exp_q.pop_front()));
            sk = skq.pop_front();
            if (have_done && gen_resp) begin
               last_d2r = cyc - done_cyc;
               chk("done_to_refresh", 32'(last_d2r), 32'(int'(rg_efuse_tgap) + 1 + sk));
            end
            if (have_prev_ref && !gen_resp)
               chk("timeout_interval", 32'(cyc - prev_ref_cyc),
                   32'(3 + int'(rg_efuse_tpgm) + TMO + int'(rg_efuse_tgap) + sk));
         end
         prev_ref_cyc  = cyc;
         have_prev_ref = 1'b1;
         have_done     = 1'b0;
      end
      if (efuse_refresh && !efuse_pgmen && !efuse_rden) begin
         clr_cnt++;
         chk("clear_after_last_bit", 32'(exp_q.size()), 32'd0);
      end
      if (rdata_valid) begin
         rv_cnt++;
         chk("rdata_at_valid", rdata, exp_rdata);
         chk("err_at_valid", 32'(err), 32'(exp_err));
      end
      if (efuse_aen_done && !done_prev) begin
         have_done = 1'b1;
         done_cyc  = cyc;
      end
      done_prev = efuse_aen_done;
   end

   task automatic start_cmd(input logic w, input logic [2:0] word, input logic [31:0] data,
                            input logic hold);
      int skips = 0;
      logic [7:0] a;
      exp_q.delete(); skq.delete(); log_addr.delete(); log_cyc.delete();
      exp_rdata = 32'd0;
      for (int b = 0; b < 32; b++) begin
         a = {word, 5'(b)};
         if (a == 8'd0 || (w && !data[b])) skips++;
         else begin
            exp_q.push_back(a);
            skq.push_back(skips);
            skips = 0;
            if (!w && gen_resp) exp_rdata[b] = gen_ones ? 1'b1 : a[0];
         end
      end
      n_exp = exp_q.size();
      exp_err = !gen_resp && (n_exp > 0);
      cur_wr = w;
      acc_cnt = 0; clr_cnt = 0; rv_cnt = 0;
      have_done = 1'b0; have_prev_ref = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_write = w; cmd_word = word; cmd_wdata = data;
      @(negedge clk);
      chk("accepted", 32'(busy), 32'd1);
      if (!hold) cmd_valid = 1'b0;
      else begin
         for (int i = 0; i < 20000; i++) begin
            if (efuse_refresh && !efuse_pgmen && !efuse_rden) break;
            @(negedge clk);
         end
         cmd_valid = 1'b0;
      end
   endtask

   task automatic finish_cmd();
      int i;
      for (i = 0; i < 20000; i++) begin
         if (!busy) break;
         @(negedge clk);
      end
      chk("cmd_completes", 32'(i < 20000), 32'd1);
      chk("access_count", 32'(acc_cnt), 32'(n_exp));
      chk("clear_count", 32'(clr_cnt), 32'd1);
      chk("rdata_valid_count", 32'(rv_cnt), cur_wr ? 32'd0 : 32'd1);
      chk("err_end", 32'(err), 32'(exp_err));
      if (!cur_wr) chk("rdata_end", rdata, exp_rdata);
   endtask

   task automatic run_cmd(input logic w, input logic [2:0] word, input logic [31:0] data,
                          input logic hold);
      start_cmd(w, word, data, hold);
      finish_cmd();
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_word = 3'd0; cmd_wdata = 32'd0;
      rg_efuse_tpgm = 10'd5; rg_efuse_tgap = 4'd0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {24'd0, efuse_reg_mode, efuse_refresh, efuse_pgmen, efuse_rden,
                            rdata_valid, busy, err, cmd_ready}, 32'h1);
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_addr", 32'(efuse_addr), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Read word 2: dout = addr[0]
      run_cmd(1'b0, 3'd2, 32'd0, 1'b0);
      chk("read_w2_rdata", rdata, 32'haaaa_aaaa);
      chk("read_w2_refreshes", 32'(acc_cnt), 32'd32);

      // Program word 1 with 0x11
      run_cmd(1'b1, 3'd1, 32'h0000_0011, 1'b0);
      chk("prog_refresh_count", 32'(log_addr.size()), 32'd2);
      if (log_addr.size() == 2) begin
         chk("prog_addr0", 32'(log_addr[0]), 32'h20);
         chk("prog_addr1", 32'(log_addr[1]), 32'h24);
      end

      // All-zero program word: only the CLEAR strobe
      run_cmd(1'b1, 3'd3, 32'd0, 1'b0);
      chk("zero_prog_refreshes", 32'(acc_cnt), 32'd0);

      // Read word 0 with dout stuck at 1: reserved address 0 reads as 0
      gen_ones = 1'b1;
      run_cmd(1'b0, 3'd0, 32'd0, 1'b0);
      chk("read_w0_rdata", rdata, 32'hffff_fffe);
      chk("read_w0_refreshes", 32'(acc_cnt), 32'd31);
      gen_ones = 1'b0;

      // Generator never finishes: every bit times out
      gen_resp = 1'b0; rg_efuse_tpgm = 10'd4;
      run_cmd(1'b0, 3'd1, 32'd0, 1'b0);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_rdata", rdata, 32'd0);
      if (log_cyc.size() >= 2) chk("timeout_period", 32'(log_cyc[1] - log_cyc[0]), 32'd15);
      gen_resp = 1'b1; rg_efuse_tpgm = 10'd5;

      // tgap=3 with cmd_valid held through the command
      rg_efuse_tgap = 4'd3;
      run_cmd(1'b0, 3'd5, 32'd0, 1'b1);
      chk("gap_done_to_refresh", 32'(last_d2r), 32'd4);
      chk("gap_err_cleared", 32'(err), 32'd0);
      repeat (3) @(negedge clk);
      chk("held_valid_not_reaccepted", 32'(busy), 32'd0);
      rg_efuse_tgap = 4'd0;

      // Reset during WAIT_DONE of bit 10
      start_cmd(1'b0, 3'd3, 32'd0, 1'b0);
      for (int i = 0; i < 2000; i++) begin
         if (acc_cnt >= 11) break;
         @(negedge clk);
      end
      chk("reached_bit10", 32'(acc_cnt), 32'd11);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {24'd0, efuse_reg_mode, efuse_refresh, efuse_pgmen, efuse_rden,
                               rdata_valid, busy, err, cmd_ready}, 32'h1);
      chk("midreset_addr", 32'(efuse_addr), 32'd0);
      exp_q.delete(); skq.delete();
      acc_cnt = 0; clr_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("no_refresh_after_reset", 32'(acc_cnt + clr_cnt), 32'd0);
      run_cmd(1'b0, 3'd2, 32'd0, 1'b0);
      chk("post_reset_read", rdata, 32'haaaa_aaaa);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/efuse_seq_ctrl.md
EFUSE_SEQ_CTRL -- requirements
Module: efuse_seq_ctrl

Interface
REQ-001 SHALL have parameter TMO_MARGIN, default 8, meaning extra cycles beyond tpgm before a bit access is declared timed out.
REQ-002 SHALL have ports clk input 1 (clock) and rst_n input 1 (reset, asynchronous, active-low), listed first.
REQ-003 SHALL have cmd_valid input 1 (command request) and cmd_ready output 1 (high only in IDLE).
REQ-004 SHALL have cmd_write input 1 (1=program, 0=read), cmd_word input 3 (word index) and cmd_wdata input 32 (program data).
REQ-005 SHALL have rg_efuse_tpgm input 10 (strobe width, same value given to the AEN generator) and rg_efuse_tgap input 4 (idle cycles between bit accesses).
REQ-006 SHALL have efuse_reg_mode output 1, efuse_refresh output 1 (one-cycle pulse), efuse_pgmen output 1, efuse_rden output 1 and efuse_addr output 8, all driving the AEN generator.
REQ-007 SHALL have efuse_aen_done input 1 (level from the AEN generator) and efuse_dout input 1 (macro read bit, valid when done rises).
REQ-008 SHALL have rdata output 32, rdata_valid output 1 (one-cycle pulse), busy output 1 and err output 1 (sticky timeout flag).

Function
REQ-009 SHALL implement states IDLE, ISSUE, ARM, WAIT_DONE, GAP, CLEAR and FINISH.
REQ-010 SHALL capture the command in IDLE when cmd_valid=1: latch cmd_write, cmd_word and cmd_wdata, set bit index to 0, go to ISSUE.
REQ-011 SHALL use efuse_addr = {word, bit_idx[4:0]}, held stable from ISSUE through the end of WAIT_DONE.
REQ-012 SHALL hold efuse_pgmen=write and efuse_rden=~write through the whole command (ISSUE..GAP), both 0 in IDLE, CLEAR and FINISH; efuse_reg_mode SHALL equal busy.
REQ-013 SHALL skip a bit in ISSUE (no refresh, advance directly) when writing a 0 data bit, or when the address is 0 (address 0 is reserved; it reads as 0 and is never programmed).
REQ-014 SHALL otherwise pulse efuse_refresh for one cycle in ISSUE, then spend exactly 2 cycles in ARM ignoring efuse_aen_done, then enter WAIT_DONE.
REQ-015 SHALL leave WAIT_DONE on the first cycle efuse_aen_done=1, storing efuse_dout into rdata bit bit_idx on reads.
REQ-016 SHALL run a 10-bit timeout counter in WAIT_DONE; when it reaches rg_efuse_tpgm+TMO_MARGIN (11-bit compare), it SHALL set err, store 0 for a read bit, and leave WAIT_DONE.
REQ-017 SHALL, after WAIT_DONE, wait rg_efuse_tgap cycles in GAP (0 = no GAP cycle), then advance bit_idx; after bit 31 it SHALL go to CLEAR.
REQ-018 SHALL, in CLEAR, pulse efuse_refresh once with pgmen=rden=0 (clears the generator's previous-address register), then go to FINISH.
REQ-019 SHALL, in FINISH, pulse rdata_valid for 1 cycle on reads only, then return to IDLE; cmd_ready SHALL be high on the cycle after FINISH.
REQ-020 SHALL clear rdata to 0 at command acceptance; rdata SHALL hold its value until the next accepted read.
REQ-021 SHALL keep err sticky until the next accepted command, which clears it.
REQ-022 SHALL ignore cmd_valid while busy; no queuing.
REQ-023 SHALL give busy=1 in every state except IDLE.
REQ-024 SHALL treat an all-zero program word as 32 skips plus CLEAR, with no program strobe issued.

Reset
REQ-025 SHALL, on rst_n low, go to IDLE with all outputs 0 except cmd_ready=1, regardless of the state at the time of reset.
REQ-026 SHALL, on reset mid-operation, issue no CLEAR refresh afterwards; the AEN generator is reset by the same rst_n.

Structure
REQ-027 SHALL put the state enum, EFUSE_BITS_PER_WORD=32 and EFUSE_WORDS=8 in a shared package efuse_pkg.
REQ-028 SHALL instantiate no sub-module; it is a standalone FSM with counters.

Verification
REQ-029 Read word 2 with tpgm=5, tgap=0, and a generator model returning dout=addr[0] -> rdata=32'hAAAAAAAA, one rdata_valid, err=0, 32 refresh pulses plus 1 CLEAR pulse.
REQ-030 Program word 1 with data 32'h00000011 -> refresh pulses only at addresses 0x20 and 0x24, pgmen=1 and rden=0 throughout, no rdata_valid.
REQ-031 Read word 0 -> address 0 skipped, rdata[0]=0, exactly 31 bit-access refreshes.
REQ-032 Generator model never raises done, tpgm=4 -> each bit times out after 12 cycles in WAIT_DONE, err=1, rdata=0, command completes.
REQ-033 Assert rst_n low during WAIT_DONE of bit 10 -> next cycle IDLE, busy=0, cmd_ready=1, no refresh pulses; a new read then completes normally.
REQ-034 tgap=3 -> exactly 3 idle cycles between done and the next refresh; cmd_valid held high during the command is not accepted until IDLE.
